// File: rtl/tan_series_ctrl.sv
// tan_series_ctrl: sequencer for the tan accelerator.
// Computes tan(x) ~= x + sum_{k=1}^{N_TERMS-1} c_k * x^(2k+1) using one shared
// 16x16 multiplier. The coefficients come from an external combinational LUT.
// Optional macro TAN_SERIES_EARLY_EXIT_EN ends the run at the first zero term.
module tan_series_ctrl #(
   parameter int unsigned N_TERMS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] x_in,
   input  logic [15:0] lut_data,
   output logic [3:0]  lut_adr,
   output logic        busy,
   output logic        done,
   output logic [17:0] result
);

   typedef enum logic [2:0] {StIdle, StSquare, StPower, StTerm, StDone} state_e;

   localparam logic [3:0] KLast = 4'(N_TERMS - 1);

   state_e      state_q, state_d;
   logic [3:0]  k_q, k_d;
   logic [15:0] x_q, x_d;
   logic [15:0] x2_q, x2_d;
   logic [15:0] pow_q, pow_d;
   logic [17:0] acc_q, acc_d;
   logic [17:0] result_q, result_d;

   logic [15:0] mul_a, mul_b, mul_out;
   logic        term_last;
   logic        accept;

   // Operand select for the shared multiplier, keyed on the registered state
   always_comb begin
      mul_a = 16'h0;
      mul_b = 16'h0;
      unique case (state_q)
         StSquare: begin
            mul_a = x_q;
            mul_b = x_q;
         end
         StPower: begin
            mul_a = pow_q;
            mul_b = x2_q;
         end
         StTerm: begin
            mul_a = pow_q;
            mul_b = lut_data;
         end
         default: ;
      endcase
   end

   // Truncating Q0.16 multiply: keep the upper half of the product
   assign mul_out = 16'((32'(mul_a) * 32'(mul_b)) >> 16);

`ifdef TAN_SERIES_EARLY_EXIT_EN
   // pow never grows, so once a term is zero every later term is zero too
   assign term_last = (k_q == KLast) || (mul_out == 16'h0);
`else
   assign term_last = (k_q == KLast);
`endif

   assign accept = start && ((state_q == StIdle) || (state_q == StDone));

   // Next-state, datapath updates and decoded outputs
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      x_d      = x_q;
      x2_d     = x2_q;
      pow_d    = pow_q;
      acc_d    = acc_q;
      result_d = result_q;
      lut_adr  = 4'h0;
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         StIdle: ;
         StSquare: begin
            busy = 1'b1;
            x2_d = mul_out;
            if (N_TERMS == 1) begin
               state_d  = StDone;
               result_d = acc_q;
            end else begin
               state_d = StPower;
            end
         end
         StPower: begin
            busy    = 1'b1;
            pow_d   = mul_out;
            state_d = StTerm;
         end
         StTerm: begin
            busy    = 1'b1;
            lut_adr = k_q;
            acc_d   = acc_q + {2'b00, mul_out};
            if (term_last) begin
               state_d  = StDone;
               result_d = acc_q + {2'b00, mul_out};
            end else begin
               k_d     = k_q + 4'd1;
               state_d = StPower;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Start is honoured in IDLE and DONE alike, giving back-to-back runs
      if (accept) begin
         x_d     = x_in;
         acc_d   = {2'b00, x_in};
         pow_d   = x_in;
         k_d     = 4'd1;
         state_d = StSquare;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         k_q      <= 4'h0;
         x_q      <= 16'h0;
         x2_q     <= 16'h0;
         pow_q    <= 16'h0;
         acc_q    <= 18'h0;
         result_q <= 18'h0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         x_q      <= x_d;
         x2_q     <= x2_d;
         pow_q    <= pow_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_tan_series_ctrl.sv
// tb_tan_series_ctrl: table-driven and scoreboard bench for tan_series_ctrl.
// Honours TAN_SERIES_EARLY_EXIT_EN for expected latency.
module tb_tan_series_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] x_in = 16'h0;
   logic [15:0] lut_data;
   logic [3:0]  lut_adr;
   logic        busy, done;
   logic [17:0] result;

   int tests = 0;
   int failed = 0;

   logic [17:0] sb [$];

   // Q0.16 tan series coefficients: 1/3, 2/15, 17/315, 62/2835, ...
   logic [15:0] coef [0:15] = '{16'd0, 16'd21845, 16'd8738, 16'd3537, 16'd1433, 16'd581,
                                16'd235, 16'd95, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                                16'd0, 16'd0};

   assign lut_data = coef[lut_adr];

   tan_series_ctrl #(.N_TERMS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .x_in     (x_in),
      .lut_data (lut_data),
      .lut_adr  (lut_adr),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] mulf(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = {16'h0, a} * {16'h0, b};
      return p[31:16];
   endfunction

   // Reference series evaluation; kexit is the first TERM index with a zero term
   function automatic void model(input logic [15:0] x, output logic [17:0] res,
                                 output int kexit);
      logic [15:0] x2, pow, t;
      logic [17:0] acc;
      bit found;
      found = 1'b0;
      kexit = 7;
      acc = {2'b00, x};
      pow = x;
      x2 = mulf(x, x);
      for (int k = 1; k < 8; k++) begin
         pow = mulf(pow, x2);
         t = mulf(pow, coef[k]);
         acc = acc + {2'b00, t};
         if (t == 16'h0 && !found) begin
            found = 1'b1;
            kexit = k;
         end
      end
      res = acc;
   endfunction

   function automatic int lat_of(input int kexit);
`ifdef TAN_SERIES_EARLY_EXIT_EN
      return 1 + 2 * kexit;
`else
      return 15 + 0 * kexit;
`endif
   endfunction

   function automatic logic [3:0] exp_adr(input int c);
      return (c >= 2 && (c % 2) == 0) ? 4'(c / 2) : 4'h0;
   endfunction

   // Scoreboard: every done pulse pops one expected result
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            check("result", 32'(result), 32'(sb.pop_front()));
         end
      end
   end

   // One run: start at edge 0, per-cycle busy/lut_adr trace, latency, one-cycle done
   task automatic run(input logic [15:0] x, input logic [17:0] exp, input int lat,
                      input string nm, input bit poke);
      bit seen;
      seen = 1'b0;
      sb.push_back(exp);
      @(negedge clk);
      start = 1'b1;
      x_in = x;
      @(posedge clk);
      #1;
      start = 1'b0;
      x_in = ~x;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            check({nm, "_latency"}, 32'(c), 32'(lat));
            check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            check({nm, "_adr_at_done"}, 32'(lut_adr), 32'd0);
            seen = 1'b1;
            break;
         end
         check({nm, "_busy"}, 32'(busy), 32'd1);
         check({nm, "_lut_adr"}, 32'(lut_adr), 32'(exp_adr(c)));
         if (poke && c == 4) begin
            start = 1'b1;
            x_in = 16'h1234;
         end
         if (poke && c == 5) start = 1'b0;
      end
      if (!seen) begin
         check({nm, "_timeout"}, 32'd1, 32'd0);
         sb.delete();
      end
      @(negedge clk);
      check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
      check({nm, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [15:0] x;
      logic [17:0] exp;
      string       nm;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [17:0] r;
      int ke, ke8000, ke0;
      bit found;

      vecs[0] = '{x: 16'h8000, exp: 18'h08BD8, nm: "x_8000"};
      vecs[1] = '{x: 16'h0000, exp: 18'h00000, nm: "x_0000"};
      vecs[2] = '{x: 16'h0001, exp: 18'h00001, nm: "x_0001"};
      model(16'h4000, r, ke);
      vecs[3] = '{x: 16'h4000, exp: r, nm: "x_4000"};
      model(16'hC000, r, ke);
      vecs[4] = '{x: 16'hC000, exp: r, nm: "x_C000"};
      model(16'hFFFF, r, ke);
      vecs[5] = '{x: 16'hFFFF, exp: r, nm: "x_FFFF"};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_lut_adr", 32'(lut_adr), 32'd0);
      rst = 1'b1;

      // Table-driven runs
      for (int i = 0; i < 6; i++) begin
         model(vecs[i].x, r, ke);
         run(vecs[i].x, vecs[i].exp, lat_of(ke), vecs[i].nm, 1'b0);
      end

      // Start pulsed mid-run with another operand is ignored
      model(16'h8000, r, ke8000);
      run(16'h8000, 18'h08BD8, lat_of(ke8000), "mid_start", 1'b1);

      // Reset during TERM with k = 3
      @(negedge clk);
      start = 1'b1;
      x_in = 16'h8000;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (lut_adr == 4'd3) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_term_k3", 32'(found), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_lut_adr", 32'(lut_adr), 32'd0);
      rst = 1'b1;
      run(16'h8000, 18'h08BD8, lat_of(ke8000), "after_rst", 1'b0);

      // Start held through DONE: back-to-back runs, no IDLE gap
      model(16'h0000, r, ke0);
      sb.push_back(18'h08BD8);
      sb.push_back(18'h00000);
      @(negedge clk);
      start = 1'b1;
      x_in = 16'h8000;
      @(posedge clk);
      #1;
      found = 1'b0;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            check("b2b_lat1", 32'(c), 32'(lat_of(ke8000)));
            found = 1'b1;
            break;
         end
      end
      check("b2b_first_done", 32'(found), 32'd1);
      x_in = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      check("b2b_no_gap_busy", 32'(busy), 32'd1);
      check("b2b_no_gap_done", 32'(done), 32'd0);
      found = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            check("b2b_lat2", 32'(c), 32'(lat_of(ke0)));
            found = 1'b1;
            break;
         end
      end
      check("b2b_second_done", 32'(found), 32'd1);
      @(negedge clk);
      check("b2b_done_one_cycle", 32'(done), 32'd0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/tan_series_ctrl.md
Name: tan_series_ctrl

Overview:
- Sequencer for the tan accelerator. Evaluates tan(x) ≈ x + Σ c_k·x^(2k+1), k = 1..N_TERMS-1.
- Coefficients c_k come from the external 16-entry Q0.16 coefficient LUT: combinational, address in, data out.
- Owns one shared 16x16 multiplier, time-multiplexed across the square, power and term steps.
- Handshake is start/busy/done.

Parameters:
- N_TERMS, 8, number of series terms including the linear x term; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- x_in  in  16  argument, unsigned Q0.16 (0 <= x < 1); captured when start is accepted.
- lut_data  in  16  coefficient returned by the LUT for lut_adr, Q0.16.
- lut_adr  out  4  coefficient index driven to the LUT.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  one-cycle pulse; result valid.
- result  out  18  tan(x), unsigned Q2.16; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low.
- Reset (rst=0 at a clock edge), including mid-operation:
  - state = IDLE, k = 0.
  - busy = 0, done = 0, result = 0, lut_adr = 0.
  - Internal x, x2, pow and acc cleared.
- States: IDLE, SQUARE, POWER, TERM, DONE.
- Multiplier rule: mul(a,b) = bits [31:16] of the 32-bit unsigned product (truncation, no rounding). acc is 18 bits.
- IDLE, start=1: x ← x_in, acc ← {2'b00,x_in}, pow ← x_in, k ← 1, busy ← 1 → SQUARE.
- IDLE, start=0: stay.
- SQUARE (1 cycle): x2 ← mul(x,x).
  - N_TERMS == 1 → DONE.
  - Otherwise → POWER.
- POWER (1 cycle): pow ← mul(pow,x2) → TERM.
- TERM (1 cycle):
  - lut_adr = k.
  - acc ← acc + mul(pow,lut_data).
  - If k == N_TERMS-1 → DONE; else k ← k+1 → POWER.
- lut_adr = 0 in every state other than TERM. Decode is registered-state-based, so the LUT output is stable within the TERM cycle.
- DONE (1 cycle):
  - done = 1, busy = 0, result ← acc (registered on DONE entry).
  - start=1: accepted exactly as in IDLE (back-to-back) → SQUARE; done still pulses this cycle.
  - start=0 → IDLE.
- start while busy (SQUARE/POWER/TERM): ignored, no effect on state or operands.
- x_in changes after acceptance: no effect.
- Latency: if start is sampled at edge 0, DONE is entered at edge 1 + 2·(N_TERMS-1). That is edge 15 for N_TERMS = 8.
- Overflow: none possible for x < 1 with the specified coefficients (max ≈ 1.557). No saturation logic.

Optional Feature:
- Macro: TAN_SERIES_EARLY_EXIT_EN.
- Defined:
  - In TERM, if mul(pow,lut_data) == 0, go to DONE after this cycle, regardless of k. acc is still updated (by +0).
  - Later terms are provably zero because pow is non-increasing, so result is identical to the full run.
  - Latency shortens to 1 + 2·k_exit.
- Undefined: always runs all N_TERMS-1 TERM steps; latency is fixed.

Test Plan:
- x_in = 16'h8000, N_TERMS = 8, start pulse:
  - TERM contributions are 2730, 273, 27, 2, 0, 0, 0.
  - result = 18'h08BD8; done one cycle.
  - Done timing: edge 15 without the macro; edge 11 with it.
- x_in = 16'h0000 → result = 0.
  - Early-exit on: done at edge 3.
  - Early-exit off: done at edge 15.
  - x_in = 16'h0001 → result = 18'h00001 with the same timing.
- lut_adr trace, full run:
  - Equals 1..7 in the seven TERM cycles.
  - 0 in every other cycle.
  - busy high edges 0..14, low at DONE.
- start pulsed again mid-run with a different x_in → ignored; result still matches the first operand.
- rst=0 asserted during TERM (k = 3) → next cycle: IDLE, busy = 0, done = 0, result = 0, lut_adr = 0; new start completes normally.
- start held high through DONE with x_in = 16'h8000 then 16'h0000:
  - Second run starts with no IDLE gap.
  - Two done pulses; result 18'h08BD8 then 0.
